// File: rtl/uart_rx_buffer_if.sv
// Receive-buffer bus: write side from the UART receiver, read side to the consumer,
// plus status and sticky error flags. The buffer uses the slave modport.
interface uart_rx_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
);
    logic                     flush;
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     rd_en;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     underflow;
    logic                     clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive FIFO with wrap-bit pointers, level/threshold flags and sticky errors.
// Define UART_RX_BUFFER_FWFT_EN for first-word-fall-through reads (default: registered reads).
module uart_rx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    uart_rx_buffer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level;
    logic                  full;
    logic                  empty;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic                  overflow;
    logic                  underflow;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level = wr_ptr - rd_ptr;

    // A write into a full buffer is still accepted when a read frees the slot that cycle.
    assign rd_acc  = bus.rd_en && !empty && !bus.flush;
    assign wr_acc  = bus.wr_en && (!full || rd_acc) && !bus.flush;
    assign ovf_evt = bus.wr_en && full && !rd_acc && !bus.flush;
    assign unf_evt = bus.rd_en && empty && !bus.flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && rstn) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)          overflow <= 1'b1;
            else if (bus.clr_err) overflow <= 1'b0;
            if (unf_evt)          underflow <= 1'b1;
            else if (bus.clr_err) underflow <= 1'b0;
        end
    end

`ifdef UART_RX_BUFFER_FWFT_EN
    // Head entry is presented directly; zero while empty so reset shows rd_data = 0.
    assign bus.rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_v;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= rd_acc;
            if (rd_acc) rd_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rd_v;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.level        = level;
    assign bus.almost_full  = (level >= AF_THR);
    assign bus.almost_empty = (level <= AE_THR);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per entry.
REQ-002 SHALL have parameter DEPTH, default 32, meaning entry count; power of two and >= 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, meaning almost_full asserts when level >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4, meaning almost_empty asserts when level <= AE_LEVEL.
REQ-005 SHALL have port clk, input, 1 bit, meaning clock; all logic on rising edge.
REQ-006 SHALL have port rstn, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1 bit, meaning synchronous clear of contents.
REQ-008 SHALL have port wr_en, input, 1 bit, meaning write request from the UART receiver.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH bits, meaning write data.
REQ-010 SHALL have port rd_en, input, 1 bit, meaning read request.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH bits, meaning read data.
REQ-012 SHALL have port rd_valid, output, 1 bit, meaning rd_data holds a valid entry.
REQ-013 SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit, meaning status flags.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1 bits, meaning current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow and underflow, each an output of 1 bit, meaning sticky error flags.
REQ-016 SHALL have port clr_err, input, 1 bit, meaning clear of both sticky flags.

Function
REQ-017 SHALL use binary wr_ptr and rd_ptr of $clog2(DEPTH)+1 bits, with MSB as wrap bit; empty = pointers equal; full = low bits equal and MSBs differ.
REQ-018 SHALL compute level = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1); all flags derive from registered pointers only.
REQ-019 SHALL accept a write when wr_en and (!full or read accepted same cycle); store wr_data at wr_ptr and increment wr_ptr.
REQ-020 SHALL drop a write when wr_en and full with no read accepted; memory and pointers unchanged; overflow set next cycle.
REQ-021 SHALL accept a read when rd_en and !empty; increment rd_ptr.
REQ-022 SHALL set underflow next cycle on rd_en while empty; a same-cycle write does not satisfy the read.
REQ-023 SHALL keep level unchanged on simultaneous accepted read and write, including at full.
REQ-024 SHALL wrap pointers naturally at 2^($clog2(DEPTH)+1), with no special-case logic.
REQ-025 SHALL, on flush, set wr_ptr = rd_ptr = 0 and drop any same-cycle wr_en/rd_en; flush has priority over all other actions; rd_valid = 0 next cycle; sticky flags unaffected.
REQ-026 SHALL, on clr_err, clear overflow and underflow next cycle; a same-cycle new error event takes priority and the flag stays set.
REQ-027 SHALL hold rd_data at its last value when no read is accepted.

Reset
REQ-028 SHALL, on rstn low, immediately set wr_ptr, rd_ptr, rd_valid, overflow and underflow to 0.
REQ-029 SHALL reset rd_data to 0.
REQ-030 SHALL, in reset, drive empty = 1, almost_empty = 1, full = 0, almost_full = 0 and level = 0.
REQ-031 SHALL NOT reset memory contents.
REQ-032 SHALL abort any in-flight write or read when reset is asserted mid-operation.

Configuration
REQ-033 SHALL support macro UART_RX_BUFFER_FWFT_EN.
REQ-034 SHALL, when UART_RX_BUFFER_FWFT_EN is defined, operate in first-word-fall-through mode: rd_data = memory[rd_ptr] combinationally, rd_valid = !empty, and rd_en acts as acknowledge/pop.
REQ-035 SHALL, when UART_RX_BUFFER_FWFT_EN is not defined, register rd_data on an accepted read: data appears 1 cycle after rd_en, with rd_valid high for exactly that cycle.

Verification
REQ-036 Reset then 32 writes of 0x00..0x1F, no reads -> full=1 and level=32 after the last write; almost_full=1 from level 28; 33rd write dropped and overflow=1.
REQ-037 Full buffer, simultaneous wr_en (0xAA) and rd_en -> level stays 32, overflow stays 0; 0xAA is read last, after 0x01..0x1F.
REQ-038 Empty buffer, rd_en pulse -> underflow=1, rd_valid=0, level=0; clr_err -> underflow=0 next cycle.
REQ-039 Write 3 entries, flush asserted together with wr_en -> level=0 and empty=1 next cycle; the flushed entries are never read.
REQ-040 Stream 100 bytes with interleaved rd/wr so the pointers wrap 3 times -> read order matches write order; non-FWFT latency is 1 cycle; FWFT data is visible the cycle after write.
REQ-041 Assert rstn low mid-stream with level=10 -> all flags and outputs take reset values asynchronously; first write after reset is read back correctly.
